// File: rtl/palette_pixel_expander.sv
// Expands packed 4-bit palette indices into 8-bit Y/Cr/Cb pixels, one pixel per clock.
// Word buffer feeds a single output register; a new word is taken in the same cycle the last pixel leaves.
module palette_pixel_expander #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_sof,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic              flush,
  output logic [3:0]        color_idx,
  input  logic [9:0]        color_code,
  output logic [7:0]        pix_y,
  output logic [7:0]        pix_cb,
  output logic [7:0]        pix_cr,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof
);

  localparam int unsigned PIX_PER_WORD = WORD_W / 4;
  localparam int unsigned CW = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(PIX_PER_WORD - 1);

  typedef enum logic {EMPTY, LOADED} buf_state_t;

  buf_state_t        state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [WORD_W-1:0] word_reg;
  logic              sof_reg;
  logic              ready_en;
  logic              load_out;
  logic              last_pix;
  logic              accept;
  logic [3:0]        nibble;

  logic [3:0] code_y;
  logic [2:0] code_cr;
  logic [2:0] code_cb;

  assign code_y  = color_code[9:6];
  assign code_cr = color_code[5:3];
  assign code_cb = color_code[2:0];

  always_comb begin
    nibble = '0;
    for (int unsigned k = 0; k < PIX_PER_WORD; k++) begin
      if (cnt == CW'(k)) nibble = word_reg[4*k +: 4];
    end
  end

  assign color_idx = (state == LOADED) ? nibble : 4'h0;
  assign last_pix  = (cnt == LAST_CNT);
  assign accept    = word_valid && word_ready;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    load_out   = 1'b0;
    word_ready = 1'b0;
    case (state)
      EMPTY: begin
        word_ready = ready_en && !flush;
      end
      LOADED: begin
        load_out   = !flush && (!pix_valid || pix_ready);
        word_ready = ready_en && !flush && load_out && last_pix;
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
    if (load_out) begin
      if (last_pix) begin
        state_nxt = EMPTY;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
    if (word_valid && word_ready) begin
      state_nxt = LOADED;
      cnt_nxt   = '0;
    end
    if (flush) begin
      state_nxt = EMPTY;
      cnt_nxt   = '0;
    end
  end

  // ready_en keeps word_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      cnt       <= '0;
      word_reg  <= '0;
      sof_reg   <= 1'b0;
      ready_en  <= 1'b0;
      pix_valid <= 1'b0;
      pix_sof   <= 1'b0;
      pix_y     <= '0;
      pix_cr    <= '0;
      pix_cb    <= '0;
    end else begin
      ready_en <= 1'b1;
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      if (accept) begin
        word_reg <= word_data;
        sof_reg  <= word_sof;
      end
      if (flush) begin
        pix_valid <= 1'b0;
      end else if (load_out) begin
        pix_valid <= 1'b1;
        pix_sof   <= sof_reg && (cnt == '0);
        pix_y     <= {code_y, code_y};
        pix_cr    <= {code_cr, code_cr, code_cr[2:1]};
        pix_cb    <= {code_cb, code_cb, code_cb[2:1]};
      end else if (pix_ready) begin
        pix_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_palette_pixel_expander.sv
// Directed bench for palette_pixel_expander: single word, back-to-back words, stall, flush, reset.
// Expected pixels come from a hand-computed table of palette expansions.
module tb_palette_pixel_expander;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] word_data;
  logic        word_sof;
  logic        word_valid;
  logic        word_ready;
  logic        flush;
  logic [3:0]  color_idx;
  logic [9:0]  color_code;
  logic [7:0]  pix_y, pix_cb, pix_cr;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_sof;

  logic [9:0]  pal [16];
  logic [23:0] exp_tab [6];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;

  logic [24:0] cap_q[$];
  int unsigned cap_cyc[$];
  int unsigned acc_cyc[$];

  always #5 clk = ~clk;

  assign color_code = pal[color_idx];

  palette_pixel_expander #(.WORD_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .word_data  (word_data),
    .word_sof   (word_sof),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .flush      (flush),
    .color_idx  (color_idx),
    .color_code (color_code),
    .pix_y      (pix_y),
    .pix_cb     (pix_cb),
    .pix_cr     (pix_cr),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_sof    (pix_sof)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pix_valid && pix_ready) begin
      cap_q.push_back({pix_sof, pix_y, pix_cr, pix_cb});
      cap_cyc.push_back(cyc);
    end
    if (word_valid && word_ready) acc_cyc.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_pix(input logic s, input int idx);
    return {7'h0, s, exp_tab[idx]};
  endfunction

  function automatic int nib(input logic [31:0] w, input int k);
    return int'(w[4*k +: 4]);
  endfunction

  task automatic clear_caps();
    cap_q.delete();
    cap_cyc.delete();
    acc_cyc.delete();
  endtask

  task automatic send_word(input logic [31:0] w, input logic s);
    bit got;
    got = 1'b0;
    word_data  = w;
    word_sof   = s;
    word_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = word_ready;
      @(posedge clk);
      #1;
    end
    word_valid = 1'b0;
    if (!got) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_caps(input int n);
    for (int i = 0; i < 60 && cap_q.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
    if (cap_q.size() < n) check("cap_timeout", cap_q.size(), n);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] words [4];
    logic [31:0] w;
    int          idx;
    bit          acc;

    for (int i = 0; i < 16; i++) pal[i] = 10'h000;
    pal[0] = 10'h064;
    pal[1] = 10'h117;
    pal[2] = 10'h3FF;
    pal[3] = 10'h2A8;
    pal[5] = 10'h0C9;
    exp_tab[0] = 24'h11_92_92;
    exp_tab[1] = 24'h44_49_FF;
    exp_tab[2] = 24'hFF_FF_FF;
    exp_tab[3] = 24'hAA_B6_00;
    exp_tab[4] = 24'h00_00_00;
    exp_tab[5] = 24'h33_24_24;

    reset_n    = 1'b0;
    word_data  = '0;
    word_sof   = 1'b0;
    word_valid = 1'b1;
    flush      = 1'b0;
    pix_ready  = 1'b1;

    // reset state
    #12;
    check("rst_pix_valid", pix_valid, 0);
    check("rst_word_ready", word_ready, 0);
    check("rst_color_idx", color_idx, 0);
    check("rst_pix", {pix_sof, pix_y, pix_cr, pix_cb}, 0);
    word_valid = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    #1 check("rdy_before_edge", word_ready, 0);
    @(posedge clk);
    #1 check("rdy_after_edge", word_ready, 1);

    // single word
    clear_caps();
    send_word(32'h0000_0010, 1'b1);
    wait_caps(8);
    idle(4);
    check("w1_count", cap_q.size(), 8);
    if (cap_q.size() == 8) begin
      check("w1_p0", 32'(cap_q[0]), {7'h0, 1'b1, 24'h11_92_92});
      check("w1_p1", 32'(cap_q[1]), {7'h0, 1'b0, 24'h44_49_FF});
      for (int k = 2; k < 8; k++) check($sformatf("w1_p%0d", k), 32'(cap_q[k]), {7'h0, 1'b0, 24'h11_92_92});
      check("w1_consec", cap_cyc[7] - cap_cyc[0], 7);
      check("w1_latency", cap_cyc[0] - acc_cyc[0], 2);
    end

    // four back-to-back words
    clear_caps();
    words[0] = 32'h3210_3210;
    words[1] = 32'h0123_0123;
    words[2] = 32'h1111_2222;
    words[3] = 32'h3333_0000;
    idx = 0;
    word_data  = words[0];
    word_sof   = 1'b1;
    word_valid = 1'b1;
    for (int i = 0; i < 100 && idx < 4; i++) begin
      @(negedge clk);
      acc = word_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 4) begin
          word_data = words[idx];
          word_sof  = 1'b0;
        end else begin
          word_valid = 1'b0;
        end
      end
    end
    word_valid = 1'b0;
    check("b2b_words_sent", idx, 4);
    wait_caps(32);
    idle(4);
    check("b2b_count", cap_q.size(), 32);
    check("b2b_acc_count", acc_cyc.size(), 4);
    if (cap_q.size() == 32 && acc_cyc.size() == 4) begin
      check("b2b_consec", cap_cyc[31] - cap_cyc[0], 31);
      for (int i = 1; i < 4; i++) check($sformatf("b2b_ready_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], 8);
      for (int i = 0; i < 32; i++) begin
        w = words[i/8];
        check($sformatf("b2b_p%0d", i), 32'(cap_q[i]), exp_pix(i == 0, nib(w, i % 8)));
      end
    end

    // stall at pixel 3 with a palette write to the held pixel's index
    clear_caps();
    w = 32'h3210_5321;
    send_word(w, 1'b0);
    wait_caps(3);
    pix_ready = 1'b0;
    check("stall_valid", pix_valid, 1);
    check("stall_p3", {pix_sof, pix_y, pix_cr, pix_cb}, {7'h0, 1'b0, 24'h33_24_24});
    for (int i = 0; i < 5; i++) begin
      if (i == 1) pal[5] = 10'h3FF;
      @(posedge clk);
      #1;
      check($sformatf("stall_hold%0d", i), {pix_valid, pix_y, pix_cr, pix_cb}, {7'h0, 1'b1, 24'h33_24_24});
    end
    pix_ready = 1'b1;
    wait_caps(8);
    idle(4);
    check("stall_count", cap_q.size(), 8);
    if (cap_q.size() == 8) begin
      check("stall_out_p3", 32'(cap_q[3]), {7'h0, 1'b0, 24'h33_24_24});
      for (int k = 4; k < 8; k++) check($sformatf("stall_out_p%0d", k), 32'(cap_q[k]), exp_pix(1'b0, nib(w, k)));
    end
    pal[5] = 10'h0C9;

    // flush at pixel 5 with a competing word
    clear_caps();
    send_word(32'h1032_1032, 1'b1);
    wait_caps(5);
    pix_ready  = 1'b0;
    flush      = 1'b1;
    word_data  = 32'h3333_3333;
    word_sof   = 1'b0;
    word_valid = 1'b1;
    @(negedge clk);
    check("flush_word_ready", word_ready, 0);
    @(posedge clk);
    #1;
    flush      = 1'b0;
    word_valid = 1'b0;
    pix_ready  = 1'b1;
    check("flush_pix_valid", pix_valid, 0);
    check("flush_no_accept", acc_cyc.size(), 1);
    idle(4);
    check("flush_count", cap_q.size(), 5);
    send_word(32'h0000_0321, 1'b1);
    wait_caps(13);
    idle(2);
    check("flush_restart_count", cap_q.size(), 13);
    if (cap_q.size() == 13) begin
      check("flush_new_p0", 32'(cap_q[5]), {7'h0, 1'b1, 24'h44_49_FF});
      check("flush_new_p1", 32'(cap_q[6]), {7'h0, 1'b0, 24'hFF_FF_FF});
    end

    // asynchronous reset mid-word
    clear_caps();
    send_word(32'h2222_1111, 1'b1);
    wait_caps(3);
    #3 reset_n = 1'b0;
    #1;
    check("arst_pix_valid", pix_valid, 0);
    check("arst_pix", {pix_sof, pix_y, pix_cr, pix_cb}, 0);
    check("arst_color_idx", color_idx, 0);
    check("arst_word_ready", word_ready, 0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    #1 check("arst_rdy_before_edge", word_ready, 0);
    idle(5);
    check("arst_no_partial", cap_q.size(), 3);
    send_word(32'h0000_0003, 1'b1);
    wait_caps(11);
    idle(2);
    check("arst_new_count", cap_q.size(), 11);
    if (cap_q.size() == 11) begin
      check("arst_new_p0", 32'(cap_q[3]), {7'h0, 1'b1, 24'hAA_B6_00});
      check("arst_new_p1", 32'(cap_q[4]), {7'h0, 1'b0, 24'h11_92_92});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
